// File: rtl/mem_lsu.sv
// Load/store unit between the MEM stage and the memory read/write ports.
// One request in flight: IDLE -> ACCESS (single memory cycle) -> RESP, with load alignment/extension.
module mem_lsu #(
    parameter int unsigned ADDR_W         = 64,
    parameter bit          MISALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [63:0]       mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [63:0]       mem_wdata,
    output logic [3:0]        mem_wmask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              lat_store;
    logic [ADDR_W-1:0] lat_addr;
    logic [63:0]       lat_wdata;
    logic [2:0]        lat_f3;

    logic              req_illegal;
    logic              req_misalign;
    logic              access;
    logic [63:0]       load_shift;
    logic [63:0]       load_ext;
    logic [63:0]       store_data;

    always_comb begin
        req_illegal = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
        case (req_funct3[1:0])
            2'b01:   req_misalign = req_addr[0];
            2'b10:   req_misalign = |req_addr[1:0];
            2'b11:   req_misalign = |req_addr[2:0];
            default: req_misalign = 1'b0;
        endcase
        req_misalign = req_misalign & MISALIGN_CHECK;
    end

    // Logical shift fills with zeros, so bytes past offset 7 read as 0 for unchecked misaligned loads.
    always_comb begin
        load_shift = mem_rdata >> {lat_addr[2:0], 3'b000};
        case (lat_f3)
            3'b000:  load_ext = {{56{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
            3'b010:  load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
            3'b011:  load_ext = load_shift;
            3'b100:  load_ext = {56'd0, load_shift[7:0]};
            3'b101:  load_ext = {48'd0, load_shift[15:0]};
            3'b110:  load_ext = {32'd0, load_shift[31:0]};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        case (lat_f3[1:0])
            2'b00:   store_data = {56'd0, lat_wdata[7:0]};
            2'b01:   store_data = {48'd0, lat_wdata[15:0]};
            2'b10:   store_data = {32'd0, lat_wdata[31:0]};
            default: store_data = lat_wdata;
        endcase
    end

    // Reset in the ACCESS cycle must keep the write from committing on that edge.
    assign access    = (state == ACCESS) && !rst;
    assign req_ready = (state == IDLE);
    assign mem_ren   = access && !lat_store;
    assign mem_wen   = access && lat_store;
    assign mem_raddr = mem_ren ? {lat_addr[ADDR_W-1:3], 3'b000} : '0;
    assign mem_waddr = mem_wen ? lat_addr : '0;
    assign mem_wdata = mem_wen ? store_data : '0;
    assign mem_wmask = mem_wen ? (4'b0001 << lat_f3[1:0]) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_f3     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_illegal || req_misalign) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            lat_store <= req_is_store;
                            lat_addr  <= req_addr;
                            lat_wdata <= req_wdata;
                            lat_f3    <= req_funct3;
                        end
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= lat_store ? 64'd0 : load_ext;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed-vector bench for mem_lsu: table of single requests plus backpressure and reset-in-ACCESS sequences.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_wmask;

    int tests = 0;
    int fails = 0;

    mem_lsu #(.ADDR_W(64), .MISALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  f3;
        logic [63:0] rdata_in;
        logic        err;
        logic [63:0] exp_rdata;
        logic [63:0] exp_maddr;
        logic [63:0] exp_wdata;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        req_valid    = 1'b1;
        req_is_store = v.st;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_funct3   = v.f3;
        mem_rdata    = v.rdata_in;
        check({p, "_idle_ready"}, 64'(req_ready), 64'd1);
        check({p, "_idle_ren"}, 64'(mem_ren | mem_wen), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!v.err) begin
            check({p, "_acc_ready"}, 64'(req_ready), 64'd0);
            check({p, "_acc_rvalid"}, 64'(resp_valid), 64'd0);
            check({p, "_ren"}, 64'(mem_ren), 64'(!v.st));
            check({p, "_wen"}, 64'(mem_wen), 64'(v.st));
            check({p, "_raddr"}, mem_raddr, v.st ? 64'd0 : v.exp_maddr);
            check({p, "_waddr"}, mem_waddr, v.st ? v.exp_maddr : 64'd0);
            check({p, "_wdata"}, mem_wdata, v.exp_wdata);
            check({p, "_wmask"}, 64'(mem_wmask), 64'(v.exp_mask));
            @(posedge clk); #1;
        end
        check({p, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({p, "_resp_err"}, 64'(resp_err), 64'(v.err));
        check({p, "_resp_rdata"}, resp_rdata, v.exp_rdata);
        check({p, "_resp_ready"}, 64'(req_ready), 64'd0);
        check({p, "_resp_men"}, 64'(mem_ren | mem_wen), 64'd0);
        check({p, "_resp_maddr"}, mem_raddr | mem_waddr | mem_wdata | 64'(mem_wmask), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({p, "_done_valid"}, 64'(resp_valid), 64'd0);
        check({p, "_done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] rd1;
        logic [63:0] wd;
        rd1 = 64'h1122_3344_8566_7788;
        wd  = 64'hDEAD_BEEF_CAFE_1234;
        //          st    addr                  wdata f3      rdata_in                err  exp_rdata                 maddr                 exp_wdata               mask
        vecs[0]  = '{1'b0, 64'h8000_0003, 64'd0, 3'b000, rd1,                   1'b0, 64'hFFFF_FFFF_FFFF_FF85, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[1]  = '{1'b0, 64'h8000_0004, 64'd0, 3'b110, rd1,                   1'b0, 64'h0000_0000_1122_3344, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[2]  = '{1'b0, 64'h8000_0004, 64'd0, 3'b010, rd1,                   1'b0, 64'h0000_0000_1122_3344, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[3]  = '{1'b0, 64'h8000_0004, 64'd0, 3'b010, 64'h8122_3344_0000_0000, 1'b0, 64'hFFFF_FFFF_8122_3344, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[4]  = '{1'b0, 64'h8000_0003, 64'd0, 3'b100, rd1,                   1'b0, 64'h0000_0000_0000_0085, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[5]  = '{1'b0, 64'h8000_0002, 64'd0, 3'b001, rd1,                   1'b0, 64'hFFFF_FFFF_FFFF_8566, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[6]  = '{1'b0, 64'h8000_0002, 64'd0, 3'b101, rd1,                   1'b0, 64'h0000_0000_0000_8566, 64'h8000_0000, 64'd0, 4'b0000};
        vecs[7]  = '{1'b0, 64'h8000_0008, 64'd0, 3'b011, rd1,                   1'b0, rd1,                     64'h8000_0008, 64'd0, 4'b0000};
        vecs[8]  = '{1'b1, 64'h8000_0010, wd,    3'b001, 64'd0,                 1'b0, 64'd0, 64'h8000_0010, 64'h0000_0000_0000_1234, 4'b0010};
        vecs[9]  = '{1'b1, 64'h8000_0011, wd,    3'b000, 64'd0,                 1'b0, 64'd0, 64'h8000_0011, 64'h0000_0000_0000_0034, 4'b0001};
        vecs[10] = '{1'b1, 64'h8000_0014, wd,    3'b010, 64'd0,                 1'b0, 64'd0, 64'h8000_0014, 64'h0000_0000_CAFE_1234, 4'b0100};
        vecs[11] = '{1'b1, 64'h8000_0018, wd,    3'b011, 64'd0,                 1'b0, 64'd0, 64'h8000_0018, wd,                      4'b1000};
        vecs[12] = '{1'b0, 64'h8000_0004, 64'd0, 3'b011, rd1,                   1'b1, 64'd0, 64'd0, 64'd0, 4'b0000};
        vecs[13] = '{1'b1, 64'h8000_0010, wd,    3'b100, 64'd0,                 1'b1, 64'd0, 64'd0, 64'd0, 4'b0000};
        vecs[14] = '{1'b0, 64'h8000_0000, 64'd0, 3'b111, rd1,                   1'b1, 64'd0, 64'd0, 64'd0, 4'b0000};
        vecs[15] = '{1'b1, 64'h8000_0012, wd,    3'b010, 64'd0,                 1'b1, 64'd0, 64'd0, 64'd0, 4'b0000};

        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; resp_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_en", 64'(mem_ren | mem_wen), 64'd0);
        check("rst_mem_bus", mem_raddr | mem_waddr | mem_wdata | 64'(mem_wmask), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Backpressure: response held for 5 cycles while a competing request is ignored.
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 64'h8000_0008; req_funct3 = 3'b011;
        mem_rdata = rd1;
        @(posedge clk); #1;
        req_addr = 64'h8000_0003; req_funct3 = 3'b100;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
            check($sformatf("bp%0d_rdata", c), resp_rdata, rd1);
            check($sformatf("bp%0d_err", c), 64'(resp_err), 64'd0);
            check($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
            check($sformatf("bp%0d_ren", c), 64'(mem_ren), 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_rel_valid", 64'(resp_valid), 64'd0);
        check("bp_rel_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_next_ren", 64'(mem_ren), 64'd1);
        check("bp_next_raddr", mem_raddr, 64'h8000_0000);
        @(posedge clk); #1;
        check("bp_next_rdata", resp_rdata, 64'h85);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset landing in the ACCESS cycle of an SD.
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 64'h8000_0020; req_funct3 = 3'b011;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("ra_wen_before", 64'(mem_wen), 64'd1);
        rst = 1'b1;
        #1;
        check("ra_wen_rst", 64'(mem_wen), 64'd0);
        check("ra_waddr_rst", mem_waddr, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("ra_resp_valid", 64'(resp_valid), 64'd0);
        check("ra_resp_rdata", resp_rdata, 64'd0);
        check("ra_mem_en", 64'(mem_ren | mem_wen), 64'd0);
        check("ra_mem_bus", mem_raddr | mem_waddr | mem_wdata | 64'(mem_wmask), 64'd0);
        @(posedge clk); #1;
        check("ra_req_ready", 64'(req_ready), 64'd1);
        check("ra_no_resp", 64'(resp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
